// File: rtl/debug_pkg.sv
// Shared types and constants for the debug/loader controller.
package debug_pkg;

  // Top-level controller states
  typedef enum logic [2:0] {
    StLoad,
    StWaitCmd,
    StRun,
    StDumpPc,
    StDumpReg,
    StDumpMem,
    StDone
  } state_e;

  // Per-word dump sequencing: address out, data latch/start, wait for serializer
  typedef enum logic [1:0] {
    PhAddr,
    PhLatch,
    PhWait
  } phase_e;

  // Word serializer states
  typedef enum logic [1:0] {
    TxIdle,
    TxWait,
    TxGap
  } tx_state_e;

  localparam logic [7:0] CMD_RUN = 8'h00;
  localparam logic [7:0] CMD_STEP = 8'h01;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/debug_word_tx.sv
// Serializes one word into bytes (LSB first) over the UART tx handshake:
// drive byte + one-cycle start pulse, wait for tx done, one idle cycle, next byte.
module debug_word_tx #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH_UART = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [DATA_WIDTH-1:0]      i_word,
  output logic                       o_busy,
  output logic                       o_word_done,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_data,
  input  logic                       i_tx_done
);
  import debug_pkg::*;

  tx_state_e                  r_state;
  logic [1:0]                 r_byte_idx;
  logic [DATA_WIDTH-1:0]      r_word;
  logic                       r_tx_signal;
  logic [DATA_WIDTH_UART-1:0] r_tx_data;
  logic                       r_word_done;

  // Byte sequencer; r_word is shifted down so the next byte is always at [2*U-1:U]
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= TxIdle;
      r_byte_idx  <= '0;
      r_word      <= '0;
      r_tx_signal <= 1'b0;
      r_tx_data   <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_tx_signal <= 1'b0;
      r_word_done <= 1'b0;
      unique case (r_state)
        TxIdle: begin
          if (i_start) begin
            r_word      <= i_word;
            r_tx_data   <= i_word[DATA_WIDTH_UART-1:0];
            r_tx_signal <= 1'b1;
            r_byte_idx  <= '0;
            r_state     <= TxWait;
          end
        end
        TxWait: begin
          if (i_tx_done) begin
            if (r_byte_idx == 2'(BYTES_PER_WORD - 1)) begin
              r_word_done <= 1'b1;
              r_state     <= TxIdle;
            end else begin
              r_state <= TxGap;
            end
          end
        end
        TxGap: begin
          r_byte_idx  <= r_byte_idx + 2'd1;
          r_tx_data   <= r_word[2*DATA_WIDTH_UART-1:DATA_WIDTH_UART];
          r_word      <= r_word >> DATA_WIDTH_UART;
          r_tx_signal <= 1'b1;
          r_state     <= TxWait;
        end
        default: r_state <= TxIdle;
      endcase
    end
  end

  assign o_busy      = (r_state != TxIdle);
  assign o_word_done = r_word_done;
  assign o_tx_signal = r_tx_signal;
  assign o_tx_data   = r_tx_data;

endmodule

// File: rtl/debug_unit.sv
// Debug/loader controller between the UART core and the MIPS pipeline.
// Loads instructions from rx bytes, runs the CPU to halt, then dumps PC,
// registers and data memory over tx. Optional single-step command is
// enabled by defining DEBUG_STEP_MODE_EN.
module debug_unit #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH_UART = 8,
  parameter int unsigned IMEM_ADDR_WIDTH = 8,
  parameter int unsigned NB_REGS         = 32,
  parameter int unsigned NB_MEM_WORDS    = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_rx_done,
  input  logic [DATA_WIDTH_UART-1:0] i_rx_data,
  input  logic                       i_tx_done,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_data,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [DATA_WIDTH-1:0]      o_imem_data,
  output logic                       o_cpu_reset,
  output logic                       o_cpu_enable,
  input  logic                       i_halt,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [4:0]                 o_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_reg_data,
  output logic [4:0]                 o_mem_addr,
  input  logic [DATA_WIDTH-1:0]      i_mem_data,
  output logic                       o_done
);
  import debug_pkg::*;

  localparam int unsigned ShiftWidth = DATA_WIDTH - DATA_WIDTH_UART;
  localparam logic [IMEM_ADDR_WIDTH:0] LastWord = {1'b0, {IMEM_ADDR_WIDTH{1'b1}}};

  state_e                     r_state;
  phase_e                     r_phase;
  logic [1:0]                 r_byte_cnt;
  logic [ShiftWidth-1:0]      r_shift;
  logic [IMEM_ADDR_WIDTH:0]   r_word_cnt;
  logic                       r_imem_we;
  logic [IMEM_ADDR_WIDTH-1:0] r_imem_addr;
  logic [DATA_WIDTH-1:0]      r_imem_data;
  logic [DATA_WIDTH-1:0]      r_pc;
  logic [DATA_WIDTH-1:0]      r_tx_word;
  logic                       r_tx_start;
  logic [4:0]                 r_idx;
`ifdef DEBUG_STEP_MODE_EN
  logic                       r_step;
  logic                       r_step_halt;
`endif

  logic [DATA_WIDTH-1:0]      w_word;
  logic                       w_word_is_halt;
  logic [DATA_WIDTH-1:0]      w_dump_word;
  logic                       w_dump_last;
  state_e                     w_next_state;
  logic                       w_tx_busy;
  logic                       w_word_done;

  // First three bytes sit in r_shift (little-endian); the 4th arrives live
  assign w_word         = {i_rx_data, r_shift};
  assign w_word_is_halt = (w_word[DATA_WIDTH-1 -: 6] == HALT_OPCODE);

  // Dump source selection, last-word detect and successor state per dump section
  always_comb begin
    w_dump_word  = i_mem_data;
    w_dump_last  = 1'b1;
    w_next_state = StDone;
    unique case (r_state)
      StDumpPc: begin
        w_dump_word  = r_pc;
        w_next_state = StDumpReg;
      end
      StDumpReg: begin
        w_dump_word  = i_reg_data;
        w_dump_last  = (r_idx == 5'(NB_REGS - 1));
        w_next_state = StDumpMem;
      end
      StDumpMem: begin
        w_dump_last = (r_idx == 5'(NB_MEM_WORDS - 1));
`ifdef DEBUG_STEP_MODE_EN
        if (r_step && !r_step_halt) w_next_state = StWaitCmd;
`endif
      end
      default: ;
    endcase
  end

  // Main controller FSM
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= StLoad;
      r_phase     <= PhAddr;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_word_cnt  <= '0;
      r_imem_we   <= 1'b0;
      r_imem_addr <= '0;
      r_imem_data <= '0;
      r_pc        <= '0;
      r_tx_word   <= '0;
      r_tx_start  <= 1'b0;
      r_idx       <= '0;
`ifdef DEBUG_STEP_MODE_EN
      r_step      <= 1'b0;
      r_step_halt <= 1'b0;
`endif
    end else begin
      r_imem_we  <= 1'b0;
      r_tx_start <= 1'b0;
      unique case (r_state)
        StLoad: begin
          if (i_rx_done) begin
            r_shift    <= {i_rx_data, r_shift[ShiftWidth-1:DATA_WIDTH_UART]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
              r_imem_we   <= 1'b1;
              r_imem_addr <= r_word_cnt[IMEM_ADDR_WIDTH-1:0];
              r_imem_data <= w_word;
              r_word_cnt  <= r_word_cnt + 1'b1;
              if (w_word_is_halt || r_word_cnt == LastWord) r_state <= StWaitCmd;
            end
          end
        end
        StWaitCmd: begin
          if (i_rx_done) begin
            if (i_rx_data == CMD_RUN) begin
              r_state <= StRun;
`ifdef DEBUG_STEP_MODE_EN
            end else if (i_rx_data == CMD_STEP) begin
              r_state <= StRun;
              r_step  <= 1'b1;
`endif
            end
          end
        end
        StRun: begin
`ifdef DEBUG_STEP_MODE_EN
          // A step allows exactly one enabled cycle, then dumps
          if (r_step) begin
            r_pc        <= i_pc;
            r_step_halt <= i_halt;
            r_phase     <= PhAddr;
            r_state     <= StDumpPc;
          end else
`endif
          if (i_halt) begin
            r_pc    <= i_pc;
            r_phase <= PhAddr;
            r_state <= StDumpPc;
          end
        end
        StDumpPc, StDumpReg, StDumpMem: begin
          unique case (r_phase)
            // Address (r_idx) is already presented; read data is valid next cycle
            PhAddr: r_phase <= PhLatch;
            PhLatch: begin
              if (!w_tx_busy) begin
                r_tx_word  <= w_dump_word;
                r_tx_start <= 1'b1;
                r_phase    <= PhWait;
              end
            end
            PhWait: begin
              if (w_word_done) begin
                r_phase <= PhAddr;
                if (w_dump_last) begin
                  r_idx   <= '0;
                  r_state <= w_next_state;
`ifdef DEBUG_STEP_MODE_EN
                  if (r_state == StDumpMem) r_step <= 1'b0;
`endif
                end else begin
                  r_idx <= r_idx + 5'd1;
                end
              end
            end
            default: r_phase <= PhAddr;
          endcase
        end
        StDone: ;
        default: r_state <= StLoad;
      endcase
    end
  end

  debug_word_tx #(
    .DATA_WIDTH     (DATA_WIDTH),
    .DATA_WIDTH_UART(DATA_WIDTH_UART)
  ) u_word_tx (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (r_tx_start),
    .i_word     (r_tx_word),
    .o_busy     (w_tx_busy),
    .o_word_done(w_word_done),
    .o_tx_signal(o_tx_signal),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done)
  );

  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_data  = r_imem_data;
  assign o_cpu_reset  = (r_state == StLoad);
  // Combinational so the cycle in which halt is raised is never clocked
  assign o_cpu_enable = (r_state == StRun) & ~i_halt;
  assign o_reg_addr   = r_idx;
  assign o_mem_addr   = r_idx;
  assign o_done       = (r_state == StDone);

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: load, run-to-halt, full dump, reset abort,
// slow tx handshake and the optional step command (DEBUG_STEP_MODE_EN).
module tb_debug_unit;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_rx_done = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_tx_done = 1'b0;
  logic        o_tx_signal;
  logic [7:0]  o_tx_data;
  logic        o_imem_we;
  logic [7:0]  o_imem_addr;
  logic [31:0] o_imem_data;
  logic        o_cpu_reset;
  logic        o_cpu_enable;
  logic        i_halt = 1'b0;
  logic [31:0] i_pc = 32'h0;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data = 32'h0;
  logic [4:0]  o_mem_addr;
  logic [31:0] i_mem_data = 32'h0;
  logic        o_done;

  always #5 i_clock = ~i_clock;

  debug_unit #(
    .DATA_WIDTH     (32),
    .DATA_WIDTH_UART(8),
    .IMEM_ADDR_WIDTH(8),
    .NB_REGS        (32),
    .NB_MEM_WORDS   (32)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rx_done   (i_rx_done),
    .i_rx_data   (i_rx_data),
    .i_tx_done   (i_tx_done),
    .o_tx_signal (o_tx_signal),
    .o_tx_data   (o_tx_data),
    .o_imem_we   (o_imem_we),
    .o_imem_addr (o_imem_addr),
    .o_imem_data (o_imem_data),
    .o_cpu_reset (o_cpu_reset),
    .o_cpu_enable(o_cpu_enable),
    .i_halt      (i_halt),
    .i_pc        (i_pc),
    .o_reg_addr  (o_reg_addr),
    .i_reg_data  (i_reg_data),
    .o_mem_addr  (o_mem_addr),
    .i_mem_data  (i_mem_data),
    .o_done      (o_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Register file / data memory models with one-cycle read latency
  always @(posedge i_clock) begin
    i_reg_data <= 32'(o_reg_addr) * 32'h01010101;
    i_mem_data <= 32'hA000_0000 | 32'(o_mem_addr);
  end

  // Monitors sampled mid-cycle
  int          we_n = 0;
  logic [7:0]  we_addr[4];
  logic [31:0] we_data[4];
  int          en_cnt = 0;
  int          sig_cnt = 0;
  always @(negedge i_clock) begin
    if (o_imem_we) begin
      if (we_n < 4) begin
        we_addr[we_n] = o_imem_addr;
        we_data[we_n] = o_imem_data;
      end
      we_n++;
    end
    if (o_cpu_enable) en_cnt++;
    if (o_tx_signal) sig_cnt++;
  end

  // UART tx responder: records each byte, checks it stays stable, then pulses done
  logic [7:0] tx_bytes[300];
  int         tx_n = 0;
  int         done_n = 0;
  int         unstable_n = 0;
  int         slow_bytes = 0;
  logic [7:0] tx_hold;
  int         tx_delay;
  initial forever begin
    @(negedge i_clock);
    if (o_tx_signal) begin
      tx_hold  = o_tx_data;
      tx_delay = (tx_n < slow_bytes) ? 500 : 2;
      if (tx_n < 300) tx_bytes[tx_n] = tx_hold;
      tx_n++;
      repeat (tx_delay) begin
        @(negedge i_clock);
        if (o_tx_data !== tx_hold) unstable_n++;
      end
      i_tx_done = 1'b1;
      done_n++;
      @(negedge i_clock);
      i_tx_done = 1'b0;
    end
  end

  function automatic logic [31:0] tx_word(input int base);
    return {tx_bytes[base+3], tx_bytes[base+2], tx_bytes[base+1], tx_bytes[base]};
  endfunction

  task automatic send_rx(input logic [7:0] b);
    @(negedge i_clock);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clock);
    i_rx_done = 1'b0;
    repeat (2) @(negedge i_clock);
  endtask

  task automatic wait_tx_count(input string tag, input int n, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clock);
      if (done_n >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clock);
      if (o_done) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  int en_at_halt;

  initial begin
    // Reset state
    repeat (3) @(negedge i_clock);
    check("rst_cpu_reset", 32'(o_cpu_reset), 32'd1);
    check("rst_cpu_enable", 32'(o_cpu_enable), 32'd0);
    check("rst_tx_signal", 32'(o_tx_signal), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_imem_we", 32'(o_imem_we), 32'd0);
    check("rst_imem_addr", 32'(o_imem_addr), 32'd0);
    check("rst_imem_data", o_imem_data, 32'd0);
    check("rst_reg_addr", 32'(o_reg_addr), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    i_reset = 1'b0;

    // Partial word then reset: bytes must be discarded
    send_rx(8'hAA);
    send_rx(8'hBB);
    @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    check("abort_no_write", 32'(we_n), 32'd0);

    // Load two instructions
    send_rx(8'h01); send_rx(8'h00); send_rx(8'h23); send_rx(8'h8C);
    check("load0_count", 32'(we_n), 32'd1);
    check("load0_addr", 32'(we_addr[0]), 32'd0);
    check("load0_data", we_data[0], 32'h8C230001);
    check("load0_cpu_reset", 32'(o_cpu_reset), 32'd1);
    send_rx(8'h00); send_rx(8'h00); send_rx(8'h00); send_rx(8'hFC);
    check("load1_count", 32'(we_n), 32'd2);
    check("load1_addr", 32'(we_addr[1]), 32'd1);
    check("load1_data", we_data[1], 32'hFC000000);
    check("wait_cpu_reset", 32'(o_cpu_reset), 32'd0);

    // Non-command byte ignored in WAIT_CMD
    send_rx(8'h05);
    repeat (5) @(negedge i_clock);
    check("wait_ignore_05", 32'(en_cnt), 32'd0);

`ifdef DEBUG_STEP_MODE_EN
    en_cnt = 0; tx_n = 0; done_n = 0; sig_cnt = 0;
    send_rx(8'h01);
    wait_tx_count("step_dump_timeout", 260, 20000);
    repeat (10) @(negedge i_clock);
    check("step_enable_cycles", 32'(en_cnt), 32'd1);
    check("step_tx_bytes", 32'(sig_cnt), 32'd260);
    check("step_reg1", tx_word(8), 32'h01010101);
    check("step_mem31", tx_word(256), 32'hA000001F);
    check("step_not_done", 32'(o_done), 32'd0);
    check("step_cpu_reset", 32'(o_cpu_reset), 32'd0);
`else
    en_cnt = 0; tx_n = 0;
    send_rx(8'h01);
    repeat (20) @(negedge i_clock);
    check("nostep_enable", 32'(en_cnt), 32'd0);
    check("nostep_no_tx", 32'(tx_n), 32'd0);
`endif

    // Run to halt with a slow tx side on the first bytes
    en_cnt = 0; tx_n = 0; done_n = 0; sig_cnt = 0; unstable_n = 0;
    slow_bytes = 6;
    send_rx(8'h00);
    check("run_enable", 32'(o_cpu_enable), 32'd1);
    i_pc   = 32'h00000038;
    i_halt = 1'b1;
    #1;
    check("halt_enable_low", 32'(o_cpu_enable), 32'd0);
    en_at_halt = en_cnt;
    @(negedge i_clock);
    i_halt = 1'b0;
    i_pc   = 32'h0;
    check("dump_enable_low", 32'(o_cpu_enable), 32'd0);

    // Bytes during the dump must be ignored
    send_rx(8'h00); send_rx(8'h01); send_rx(8'hFF); send_rx(8'h8C);

    wait_done("dump_timeout", 40000);
    repeat (5) @(negedge i_clock);
    check("dump_done_pulses", 32'(done_n), 32'd260);
    check("dump_tx_signals", 32'(sig_cnt), 32'd260);
    check("dump_tx_stable", 32'(unstable_n), 32'd0);
    check("dump_no_imem_we", 32'(we_n), 32'd2);
    check("dump_no_enable", 32'(en_cnt), 32'(en_at_halt));
    check("pc_byte0", 32'(tx_bytes[0]), 32'h38);
    check("pc_word", tx_word(0), 32'h00000038);
    check("reg0_word", tx_word(4), 32'h00000000);
    check("reg1_word", tx_word(8), 32'h01010101);
    check("reg31_word", tx_word(128), 32'h1F1F1F1F);
    check("mem0_word", tx_word(132), 32'hA0000000);
    check("mem31_word", tx_word(256), 32'hA000001F);

    // DONE ignores further rx
    send_rx(8'h00);
    repeat (5) @(negedge i_clock);
    check("done_held", 32'(o_done), 32'd1);
    check("done_enable_low", 32'(o_cpu_enable), 32'd0);
    check("done_no_tx", 32'(tx_n), 32'd260);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
